// File: rtl/bus_gnrtr_pkg.sv
// rtl/bus_gnrtr_pkg.sv - shared types, constants and ID-field helper for the bus generator/arbiter
//
// Purpose: FSM state encoding, arbitration-mode constants, the default
// broadcast ID and a helper that extracts the destination-ID field from
// the top ID_W bits of a packet.
// Ports: none (package).

package bus_gnrtr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  localparam int unsigned  DEF_ID_W  = 8;
  localparam logic [7:0]   DEF_BCAST = 8'hFF;

  // Widest packet / ID the helper can handle; callers zero-extend into it.
  localparam int unsigned PKT_MAX_W = 256;
  localparam int unsigned ID_MAX_W  = 32;

  // Returns pkt[pkt_w-1 -: id_w], right-aligned and zero-extended.
  function automatic logic [ID_MAX_W-1:0] id_field(
    input logic [PKT_MAX_W-1:0] pkt,
    input int unsigned          pkt_w,
    input int unsigned          id_w
  );
    logic [PKT_MAX_W-1:0] sh;
    logic [PKT_MAX_W-1:0] msk;
    sh  = pkt >> (pkt_w - id_w);
    msk = (PKT_MAX_W'(1) << id_w) - PKT_MAX_W'(1);
    return ID_MAX_W'(sh & msk);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - fixed-priority / round-robin request arbiter with owned pointer
//
// Purpose: combinationally selects one requester. In fixed mode the lowest
// set index wins; in round-robin mode the search starts at ptr+1 and wraps.
// The pointer moves to the winner only when advance_i is high.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (pointer -> N-1)
//   req_i     in   N request bits
//   mode_i    in   ARB_FIXED / ARB_RR
//   advance_i in   commit the current grant (update pointer)
//   gnt_o     out  one-hot grant, zero when no request
//   gnt_idx_o out  index of the granted requester

module rr_arbiter
  import bus_gnrtr_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             mode_i,
  input  logic             advance_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;

  always_comb begin
    found     = 1'b0;
    gnt_idx_o = '0;
    gnt_o     = '0;
    if (mode_i == ARB_RR) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (int'(ptr_q) + k) % N;
        if (!found && req_i[idx]) begin
          found     = 1'b1;
          gnt_idx_o = IDX_W'(idx);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_i[i]) begin
          found     = 1'b1;
          gnt_idx_o = IDX_W'(i);
        end
      end
    end
    if (found) gnt_o[gnt_idx_o] = 1'b1;
  end

  // Pointer starts at N-1 so that device 0 is first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(N - 1);
    end else if (advance_i && found) begin
      ptr_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/bus_gnrtr_arbiter_n.sv
// rtl/bus_gnrtr_arbiter_n.sv - shared-bus generator/arbiter for DRVRS device FIFOs
//
// Purpose: three-state loop (IDLE -> POP -> PUSH) moving one packet per three
// cycles from the winning device FIFO to its destination(s): unicast,
// broadcast (all but the source) or dropped with a saturating drop counter.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   pndng     in   per-device FIFO non-empty
//   D_pop     in   per-device head-of-FIFO data, lane i = [i*PCKG_SZ +: PCKG_SZ]
//   pop       out  one-hot pop strobe to the winning source
//   push      out  push strobe(s) to destination device(s)
//   D_push    out  delivered packet, replicated on every lane
//   busy      out  high while in POP or PUSH
//   drop_cnt  out  saturating count of invalid-destination drops

module bus_gnrtr_arbiter_n
  import bus_gnrtr_pkg::*;
#(
  parameter int              DRVRS    = 4,
  parameter int              PCKG_SZ  = 32,
  parameter int              ID_W     = 8,
  parameter logic [ID_W-1:0] BCAST    = {ID_W{1'b1}},
  parameter int              ARB_MODE = 1,
  parameter int              CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]           pop,
  output logic [DRVRS-1:0]           push,
  output logic [DRVRS*PCKG_SZ-1:0]   D_push,
  output logic                       busy,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int IDX_W = $clog2(DRVRS);

  state_e                     state_q, state_d;
  logic [DRVRS-1:0]           pop_q, pop_d;
  logic [DRVRS-1:0]           push_q, push_d;
  logic [DRVRS*PCKG_SZ-1:0]   d_push_q, d_push_d;
  logic                       busy_q, busy_d;
  logic [CNT_W-1:0]           drop_q, drop_d;
  logic [IDX_W-1:0]           win_q, win_d;

  logic [DRVRS-1:0]           gnt;
  logic [IDX_W-1:0]           gnt_idx;
  logic                       advance;
  logic                       arb_mode;
  logic [PCKG_SZ-1:0]         sel_pkt;
  logic [PKT_MAX_W-1:0]       sel_ext;
  logic [ID_MAX_W-1:0]        dest;

  assign arb_mode = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  rr_arbiter #(
    .N     (DRVRS),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (reset),
    .req_i     (pndng),
    .mode_i    (arb_mode),
    .advance_i (advance),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Granted source's head word; it is held valid by the source until the POP edge.
  assign sel_pkt = D_pop[int'(win_q)*PCKG_SZ +: PCKG_SZ];

  always_comb begin
    sel_ext                 = '0;
    sel_ext[PCKG_SZ-1:0]    = sel_pkt;
    dest                    = id_field(sel_ext, PCKG_SZ, ID_W);
  end

  always_comb begin
    state_d  = state_q;
    pop_d    = '0;
    push_d   = '0;
    d_push_d = d_push_q;
    busy_d   = busy_q;
    drop_d   = drop_q;
    win_d    = win_q;
    advance  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (|pndng) begin
          advance = 1'b1;
          pop_d   = gnt;
          win_d   = gnt_idx;
          busy_d  = 1'b1;
          state_d = POP;
        end
      end
      POP: begin
        d_push_d = {DRVRS{sel_pkt}};
        busy_d   = 1'b1;
        state_d  = PUSH;
        // Broadcast is checked first so it wins even if BCAST < DRVRS.
        if (dest == ID_MAX_W'(BCAST)) begin
          for (int i = 0; i < DRVRS; i++) begin
            push_d[i] = (i != int'(win_q));
          end
        end else if (dest < ID_MAX_W'(DRVRS)) begin
          push_d[dest[IDX_W-1:0]] = 1'b1;
        end else if (drop_q != {CNT_W{1'b1}}) begin
          drop_d = drop_q + CNT_W'(1);
        end
      end
      PUSH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pop_q    <= '0;
      push_q   <= '0;
      d_push_q <= '0;
      busy_q   <= 1'b0;
      drop_q   <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      pop_q    <= pop_d;
      push_q   <= push_d;
      d_push_q <= d_push_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      win_q    <= win_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = d_push_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_gnrtr_arbiter_n.sv
// tb/tb_bus_gnrtr_arbiter_n.sv - self-checking bench: round-robin and fixed/2-bit-counter instances

module tb_bus_gnrtr_arbiter_n;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   pndng;
  logic [127:0] D_pop;

  logic [3:0]   pop_a, push_a, pop_b, push_b;
  logic [127:0] dpush_a, dpush_b;
  logic         busy_a, busy_b;
  logic [15:0]  drop_a;
  logic [1:0]   drop_b;

  int tests = 0;
  int fails = 0;

  int          ptr;
  int          cnt_a, cnt_b;
  logic [31:0] held_a, held_b;
  logic [31:0] d [4];

  always #5 clk = ~clk;

  bus_gnrtr_arbiter_n #(.ARB_MODE(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop_a), .push(push_a), .D_push(dpush_a), .busy(busy_a), .drop_cnt(drop_a)
  );

  bus_gnrtr_arbiter_n #(.ARB_MODE(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop_b), .push(push_b), .D_push(dpush_b), .busy(busy_b), .drop_cnt(drop_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic int fixed_pick(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] deliver(input logic [31:0] pkt, input int w);
    logic [3:0] m;
    int dst;
    dst = int'(pkt[31:24]);
    for (int i = 0; i < 4; i++) m[i] = (dst == 255) ? (i != w) : (dst == i);
    return m;
  endfunction

  function automatic bit is_drop(input logic [31:0] pkt);
    return (pkt[31:24] != 8'hFF) && (int'(pkt[31:24]) >= 4);
  endfunction

  function automatic logic [31:0] rand_pkt();
    int r;
    logic [7:0] dst;
    r = $urandom_range(0, 5);
    if (r < 4)       dst = 8'(r);
    else if (r == 4) dst = 8'hFF;
    else             dst = 8'($urandom_range(4, 254));
    return {dst, 24'($urandom)};
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_pop_a"},  128'(pop_a),  128'(0));
    chk({tag, "_push_a"}, 128'(push_a), 128'(0));
    chk({tag, "_busy_a"}, 128'(busy_a), 128'(0));
    chk({tag, "_pop_b"},  128'(pop_b),  128'(0));
    chk({tag, "_push_b"}, 128'(push_b), 128'(0));
    chk({tag, "_busy_b"}, 128'(busy_b), 128'(0));
  endtask

  task automatic xfer(input string tag, input logic [3:0] req);
    int wa, wb;
    logic [31:0] pa, pb;
    @(negedge clk);
    pndng = req;
    D_pop = {d[3], d[2], d[1], d[0]};
    @(posedge clk); #1;
    if (req == 4'b0000) begin
      check_quiet({tag, "_noreq"});
      return;
    end
    wa  = rr_pick(req, ptr);
    wb  = fixed_pick(req);
    ptr = wa;
    chk({tag, "_pop_a"},  128'(pop_a),  128'(onehot(wa)));
    chk({tag, "_pop_b"},  128'(pop_b),  128'(onehot(wb)));
    chk({tag, "_busy1_a"}, 128'(busy_a), 128'(1));
    chk({tag, "_push0_a"}, 128'(push_a), 128'(0));
    chk({tag, "_push0_b"}, 128'(push_b), 128'(0));
    @(posedge clk); #1;
    pa = d[wa];
    pb = d[wb];
    if (is_drop(pa) && cnt_a < 65535) cnt_a++;
    if (is_drop(pb) && cnt_b < 3) cnt_b++;
    held_a = pa;
    held_b = pb;
    chk({tag, "_push_a"},  128'(push_a),  128'(deliver(pa, wa)));
    chk({tag, "_push_b"},  128'(push_b),  128'(deliver(pb, wb)));
    chk({tag, "_dpush_a"}, dpush_a,       {4{pa}});
    chk({tag, "_dpush_b"}, dpush_b,       {4{pb}});
    chk({tag, "_drop_a"},  128'(drop_a),  128'(cnt_a));
    chk({tag, "_drop_b"},  128'(drop_b),  128'(cnt_b));
    chk({tag, "_pop1_a"},  128'(pop_a),   128'(0));
    chk({tag, "_busy2_b"}, 128'(busy_b),  128'(1));
    @(posedge clk); #1;
    check_quiet({tag, "_end"});
    chk({tag, "_hold_a"}, dpush_a, {4{held_a}});
    chk({tag, "_hold_b"}, dpush_b, {4{held_b}});
    pndng = 4'b0000;
  endtask

  initial begin
    reset  = 1'b0;
    pndng  = 4'b0000;
    D_pop  = '0;
    ptr    = 3;
    cnt_a  = 0;
    cnt_b  = 0;
    held_a = '0;
    held_b = '0;
    for (int i = 0; i < 4; i++) d[i] = '0;

    // Reset held, then long idle.
    repeat (3) begin
      @(posedge clk); #1;
      check_quiet("rst");
      chk("rst_drop_a",  128'(drop_a), 128'(0));
      chk("rst_dpush_a", dpush_a,      128'(0));
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      check_quiet("idle");
      chk("idle_drop_a", 128'(drop_a), 128'(0));
      chk("idle_drop_b", 128'(drop_b), 128'(0));
    end

    // Unicast from device 0 to device 2.
    d[0] = 32'h02AA_BBCC;
    xfer("unicast", 4'b0001);
    // Broadcast from device 2.
    d[2] = 32'hFF00_0001;
    xfer("bcast", 4'b0100);
    // Invalid destination from device 1, then saturation of the 2-bit counter.
    d[1] = 32'h0700_0000;
    for (int i = 0; i < 5; i++) xfer("drop", 4'b0010);
    chk("sat_drop_b", 128'(drop_b), 128'(3));
    chk("sat_drop_a", 128'(drop_a), 128'(5));

    // Fairness with all devices requesting.
    for (int i = 0; i < 4; i++) d[i] = {8'(i), 24'h00_0000 | 24'(i)};
    for (int i = 0; i < 5; i++) xfer("fair", 4'b1111);

    // Reset asserted during POP.
    for (int i = 0; i < 4; i++) d[i] = rand_pkt();
    @(negedge clk);
    pndng = 4'b1111;
    D_pop = {d[3], d[2], d[1], d[0]};
    @(posedge clk); #1;
    chk("midrst_pop_before", 128'(pop_a), 128'(onehot(rr_pick(4'b1111, ptr))));
    #2 reset = 1'b0;
    #1;
    check_quiet("midrst");
    chk("midrst_drop_a",  128'(drop_a),  128'(0));
    chk("midrst_drop_b",  128'(drop_b),  128'(0));
    chk("midrst_dpush_a", dpush_a,       128'(0));
    @(posedge clk); #1;
    check_quiet("midrst_hold");
    @(negedge clk);
    pndng  = 4'b0000;
    reset  = 1'b1;
    ptr    = 3;
    cnt_a  = 0;
    cnt_b  = 0;
    held_a = '0;
    held_b = '0;
    for (int i = 0; i < 4; i++) d[i] = {8'((i + 1) % 4), 24'h5A5A00 | 24'(i)};
    xfer("postrst", 4'b1111);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) d[i] = rand_pkt();
      xfer("rand", 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_gnrtr_arbiter_n.md
Name: bus_gnrtr_arbiter_n

Overview:
- Parametrised successor of the team's shared-bus generator/arbiter.
- Connects DRVRS device FIFOs over a single shared bus. Each cycle it either arbitrates among pending devices, pops one packet, or delivers that packet to its destination (unicast or broadcast).
- New over the previous generation: selectable fixed/round-robin arbitration, configurable ID field and broadcast ID, invalid-destination drop counter, busy flag.
- Sits between the per-device FIFOs and the bus; the bus_if interface drives it in the test_bench.

Parameters:
- DRVRS, 4, number of device ports (2..16)
- PCKG_SZ, 32, packet width in bits
- ID_W, 8, destination-ID field width; field = D_pop[PCKG_SZ-1 -: ID_W]
- BCAST, {ID_W{1'b1}}, destination ID meaning broadcast
- ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- CNT_W, 16, drop-counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pndng  in  DRVRS  device i FIFO non-empty; D_pop[i] is valid while high
- D_pop  in  DRVRS x PCKG_SZ  head-of-FIFO data per device
- pop  out  DRVRS  one-hot pop strobe to the source FIFO
- push  out  DRVRS  push strobe(s) to destination device(s)
- D_push  out  DRVRS x PCKG_SZ  delivered packet, same value on all lanes
- busy  out  1  high while in state POP or PUSH
- drop_cnt  out  CNT_W  count of packets dropped for an invalid destination

Behaviour:
- Reset (reset=0, asynchronous):
  - pop=0, push=0, D_push=0, busy=0, drop_cnt=0.
  - state=IDLE; RR pointer=DRVRS-1, so device 0 wins first.
  - A packet caught mid-transfer is lost; this is intended.
- All outputs are registered.
- FSM states IDLE, POP, PUSH:
  - IDLE: at a clock edge with pndng!=0, pick winner w, set pop[w]=1, store w, go to POP. If pndng==0, stay in IDLE.
  - POP: at the edge, latch D_pop[w] into pkt, clear pop, decode the destination, drive D_push=pkt on all lanes, set push, go to PUSH.
  - PUSH: at the edge, clear push, go to IDLE. D_push holds its value until the next delivery.
- Delivery decode in POP:
  - dest==BCAST: push[i]=1 for every i!=w.
  - dest<DRVRS: push[dest]=1. A self-addressed packet (dest==w) is delivered.
  - Otherwise: push=0 and drop_cnt increments. drop_cnt saturates at all-ones and does not wrap.
- Timing:
  - pndng sampled at edge k; pop high during k..k+1; push high during k+1..k+2.
  - Earliest next arbitration is edge k+3, giving 1 packet per 3 cycles.
  - The IDLE cycle lets the source's pndng update after its pop.
- Arbitration:
  - Fixed mode: lowest set index of pndng wins.
  - RR mode: search from ptr+1 upward and wrap modulo DRVRS; first set bit wins; ptr<=w on grant. The pointer is updated only on a grant.
- pndng may change at any time. It is sampled only in IDLE; the granted source must hold its data valid until the POP edge.
- pop is always one-hot or zero. pop and push are never high in the same cycle.

Decomposition:
- Package bus_gnrtr_pkg: state enum (IDLE, POP, PUSH), ARB_FIXED/ARB_RR constants, default BCAST, and a function extracting the ID field.
- One sub-module, rr_arbiter: inputs req[DRVRS], mode, advance; outputs gnt one-hot and gnt_idx; owns the pointer and its async reset.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, pndng=0 for 20 cycles -> pop=0, push=0, busy=0, drop_cnt=0 throughout.
- Unicast: pndng=4'b0001, D_pop[0]=32'h02AA_BBCC -> pop[0] for 1 cycle, next cycle push=4'b0100 and D_push=32'h02AA_BBCC, then IDLE.
- Broadcast: device 2 sends 32'hFF00_0001 -> push=4'b1011 for one cycle, push[2]=0.
- Invalid destination: device 1 sends 32'h0700_0000 (DRVRS=4) -> push stays 0, drop_cnt goes 0->1. With CNT_W=2, 5 drops -> drop_cnt=3.
- Round-robin fairness: ARB_MODE=1, pndng=4'b1111 held constantly -> grant order 0,1,2,3,0, one grant every 3 cycles. With ARB_MODE=0 the same stimulus gives 0,0,0,...
- Reset mid-transfer: assert reset during POP -> pop/push drop to 0 immediately (async), no push occurs, and after release device 0 wins first.
